// File: rtl/vdp_vram_port_if.sv
// Bus bundle between the VDP/CPU front end and the VRAM port.
// The master drives strobes, addresses and write data. The slave returns read data and status.
interface vdp_vram_port_if #(
  parameter int VRAM_ADDR_WIDTH = 13
);
  logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr;
  logic                       vdp_dma_rd_tick;
  logic [7:0]                 vram_dout;
  logic                       cpu_addr_tick;
  logic                       cpu_addr_rd;
  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr;
  logic                       cpu_wr_tick;
  logic [7:0]                 cpu_wdata;
  logic                       cpu_rd_tick;
  logic [7:0]                 cpu_rdata;
  logic                       cpu_busy;
  logic                       cpu_overrun;

  modport master (
    output vdp_dma_addr, vdp_dma_rd_tick, cpu_addr_tick, cpu_addr_rd, cpu_addr,
           cpu_wr_tick, cpu_wdata, cpu_rd_tick,
    input  vram_dout, cpu_rdata, cpu_busy, cpu_overrun
  );

  modport slave (
    input  vdp_dma_addr, vdp_dma_rd_tick, cpu_addr_tick, cpu_addr_rd, cpu_addr,
           cpu_wr_tick, cpu_wdata, cpu_rd_tick,
    output vram_dout, cpu_rdata, cpu_busy, cpu_overrun
  );
endinterface

// File: rtl/vdp_vram_port.sv
// VRAM owner for the VDP. Video fetches always win the single RAM port; CPU accesses use the idle cycles.
// The CPU side uses a TMS9918-style auto-increment pointer and a read-ahead buffer.
// Optional build macro VDP_VRAM_OVERRUN_EN enables the sticky dropped-strobe flag cpu_overrun.
module vdp_vram_port #(
  parameter int VRAM_SIZE       = 8 * 1024,
  parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
  input  logic           pxclk,
  input  logic           reset_n,
  vdp_vram_port_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PEND_WR, PEND_RD, RD_CAP} state_t;

  state_t                     state, state_d;
  logic [VRAM_ADDR_WIDTH-1:0] ptr;
  logic [VRAM_ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]                 wdata_q;
  logic [7:0]                 rd_data;
  logic [7:0]                 vram_dout_q;
  logic [7:0]                 cpu_rdata_q;
  logic                       vid_cap;
  logic                       busy_q;

  logic ptr_load, ptr_inc, wdata_load, mem_we, cpu_rd_en;
  logic rdata_from_w, rdata_from_rd, drop, ovr_clr;
  logic any_tick, vtick;

  logic [7:0] mem [VRAM_SIZE];

  assign vtick    = bus.vdp_dma_rd_tick;
  assign any_tick = bus.cpu_addr_tick | bus.cpu_wr_tick | bus.cpu_rd_tick;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state;
    ptr_load      = 1'b0;
    ptr_inc       = 1'b0;
    wdata_load    = 1'b0;
    mem_we        = 1'b0;
    cpu_rd_en     = 1'b0;
    rdata_from_w  = 1'b0;
    rdata_from_rd = 1'b0;
    drop          = 1'b0;
    ovr_clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cpu_addr_tick) begin
          ptr_load = 1'b1;
          ovr_clr  = 1'b1;
          drop     = bus.cpu_wr_tick | bus.cpu_rd_tick;
          if (bus.cpu_addr_rd) state_d = PEND_RD;
        end else if (bus.cpu_wr_tick) begin
          wdata_load = 1'b1;
          drop       = bus.cpu_rd_tick;
          state_d    = PEND_WR;
        end else if (bus.cpu_rd_tick) begin
          state_d = PEND_RD;
        end
      end
      PEND_WR: begin
        drop = any_tick;
        if (!vtick) begin
          mem_we       = reset_n;  // a reset in this cycle abandons the store
          rdata_from_w = 1'b1;
          ptr_inc      = 1'b1;
          state_d      = IDLE;
        end
      end
      PEND_RD: begin
        drop = any_tick;
        if (!vtick) begin
          cpu_rd_en = 1'b1;
          ptr_inc   = 1'b1;
          state_d   = RD_CAP;
        end
      end
      RD_CAP: begin
        drop          = any_tick;
        rdata_from_rd = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pxclk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge pxclk) begin
    if (!reset_n) begin
      ptr         <= '0;
      wdata_q     <= '0;
      vram_dout_q <= '0;
      cpu_rdata_q <= '0;
      vid_cap     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vid_cap <= vtick;
      busy_q  <= (state_d != IDLE);
      if (vid_cap) vram_dout_q <= rd_data;
      if (ptr_load)     ptr <= bus.cpu_addr;
      else if (ptr_inc) ptr <= ptr + VRAM_ADDR_WIDTH'(1);
      if (wdata_load) wdata_q <= bus.cpu_wdata;
      if (rdata_from_w)       cpu_rdata_q <= wdata_q;
      else if (rdata_from_rd) cpu_rdata_q <= rd_data;
    end
  end

  // Single-port RAM: video owns the address whenever it ticks, otherwise the CPU pointer drives it.
  assign ram_addr = vtick ? bus.vdp_dma_addr : ptr;

  // NOTE: the array and its read register have no reset; VRAM contents survive reset and RAM macros have no reset pin.
  always_ff @(posedge pxclk) begin
    if (mem_we)             mem[ram_addr] <= wdata_q;
    if (vtick || cpu_rd_en) rd_data       <= mem[ram_addr];
  end

  assign bus.vram_dout = vram_dout_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_busy  = busy_q;

`ifdef VDP_VRAM_OVERRUN_EN
  logic overrun_q;
  // A drop and an accepted address load in the same cycle leave the flag set.
  always_ff @(posedge pxclk) begin
    if (!reset_n)     overrun_q <= 1'b0;
    else if (drop)    overrun_q <= 1'b1;
    else if (ovr_clr) overrun_q <= 1'b0;
  end
  assign bus.cpu_overrun = overrun_q;
`else
  logic unused_ovr;
  assign unused_ovr      = drop ^ ovr_clr;
  assign bus.cpu_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_vram_port.sv
// Directed bench for vdp_vram_port: video path, CPU write/read-ahead, wrap, stalls, overrun and reset.
// Inputs change on the falling edge and outputs are sampled on the falling edge after the rising edge acts.
module tb_vdp_vram_port;
  localparam int AW = 13;

`ifdef VDP_VRAM_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic pxclk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  vdp_vram_port_if #(.VRAM_ADDR_WIDTH(AW)) bus ();

  vdp_vram_port #(.VRAM_SIZE(8 * 1024)) u_dut (
    .pxclk  (pxclk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial pxclk = 1'b0;
  always #20 pxclk = ~pxclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge pxclk);
  endtask

  task automatic clear_inputs();
    bus.vdp_dma_rd_tick = 1'b0;
    bus.vdp_dma_addr    = '0;
    bus.cpu_addr_tick   = 1'b0;
    bus.cpu_addr_rd     = 1'b0;
    bus.cpu_addr        = '0;
    bus.cpu_wr_tick     = 1'b0;
    bus.cpu_wdata       = '0;
    bus.cpu_rd_tick     = 1'b0;
  endtask

  task automatic set_addr(input logic [AW-1:0] a, input logic rd);
    bus.cpu_addr_tick = 1'b1;
    bus.cpu_addr_rd   = rd;
    bus.cpu_addr      = a;
    step();
    clear_inputs();
  endtask

  // Issue one write strobe and give it one free cycle to land.
  task automatic cpu_write(input logic [7:0] d);
    bus.cpu_wr_tick = 1'b1;
    bus.cpu_wdata   = d;
    step();
    clear_inputs();
    step();
  endtask

  // Read a byte over the video path; the result appears after the second edge.
  task automatic video_read(input logic [AW-1:0] a, output logic [7:0] d);
    bus.vdp_dma_rd_tick = 1'b1;
    bus.vdp_dma_addr    = a;
    step();
    clear_inputs();
    step();
    d = bus.vram_dout;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    step();
    step();
    n_checks++; if (bus.vram_dout !== 8'h00) begin n_fail++; $display("FAIL rst_vram_dout: got %0h expected 00", bus.vram_dout); end
    n_checks++; if (bus.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_rdata: got %0h expected 00", bus.cpu_rdata); end
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", bus.cpu_busy); end
    n_checks++; if (bus.cpu_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %0b expected 0", bus.cpu_overrun); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_write_video();
    logic [7:0] d;
    set_addr(13'h0123, 1'b0);
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t1_addr_busy: got %0b expected 0", bus.cpu_busy); end
    bus.cpu_wr_tick = 1'b1;
    bus.cpu_wdata   = 8'hA5;
    step();
    clear_inputs();
    n_checks++; if (bus.cpu_busy !== 1'b1) begin n_fail++; $display("FAIL t1_wr_busy: got %0b expected 1", bus.cpu_busy); end
    step();
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t1_wr_done: got %0b expected 0", bus.cpu_busy); end
    n_checks++; if (bus.cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL t1_wr_rdata: got %0h expected a5", bus.cpu_rdata); end
    bus.vdp_dma_rd_tick = 1'b1;
    bus.vdp_dma_addr    = 13'h0123;
    step();
    clear_inputs();
    n_checks++; if (bus.vram_dout !== 8'h00) begin n_fail++; $display("FAIL t1_vid_early: got %0h expected 00", bus.vram_dout); end
    step();
    d = bus.vram_dout;
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL t1_vid_data: got %0h expected a5", d); end
  endtask

  task automatic test_video_stall();
    logic [7:0] d;
    set_addr(13'h0200, 1'b0);
    for (int i = 0; i < 10; i++) cpu_write(8'(8'h10 + i));
    set_addr(13'h0300, 1'b0);
    bus.cpu_wr_tick = 1'b1;
    bus.cpu_wdata   = 8'h77;
    step();
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      bus.vdp_dma_rd_tick = 1'b1;
      bus.vdp_dma_addr    = 13'(13'h0200 + i);
      step();
      n_checks++; if (bus.cpu_busy !== 1'b1) begin n_fail++; $display("FAIL t2_stall_busy[%0d]: got %0b expected 1", i, bus.cpu_busy); end
      if (i > 0) begin
        n_checks++;
        if (bus.vram_dout !== 8'(8'h10 + i - 1)) begin
          n_fail++; $display("FAIL t2_stream[%0d]: got %0h expected %0h", i, bus.vram_dout, 8'(8'h10 + i - 1));
        end
      end
    end
    clear_inputs();
    step();
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t2_release: got %0b expected 0", bus.cpu_busy); end
    n_checks++; if (bus.vram_dout !== 8'h19) begin n_fail++; $display("FAIL t2_stream_last: got %0h expected 19", bus.vram_dout); end
    n_checks++; if (bus.cpu_rdata !== 8'h77) begin n_fail++; $display("FAIL t2_wr_rdata: got %0h expected 77", bus.cpu_rdata); end
    video_read(13'h0300, d);
    n_checks++; if (d !== 8'h77) begin n_fail++; $display("FAIL t2_wr_landed: got %0h expected 77", d); end
  endtask

  task automatic test_read_wrap();
    logic [7:0] d;
    set_addr(13'h1FFF, 1'b0);
    cpu_write(8'h5A);
    cpu_write(8'h6B);
    video_read(13'h0000, d);
    n_checks++; if (d !== 8'h6B) begin n_fail++; $display("FAIL t3_wrap_store: got %0h expected 6b", d); end
    set_addr(13'h1FFF, 1'b1);
    n_checks++; if (bus.cpu_busy !== 1'b1) begin n_fail++; $display("FAIL t3_prefetch_busy0: got %0b expected 1", bus.cpu_busy); end
    step();
    n_checks++; if (bus.cpu_busy !== 1'b1) begin n_fail++; $display("FAIL t3_prefetch_busy1: got %0b expected 1", bus.cpu_busy); end
    step();
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t3_prefetch_done: got %0b expected 0", bus.cpu_busy); end
    n_checks++; if (bus.cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL t3_prefetch_data: got %0h expected 5a", bus.cpu_rdata); end
    bus.cpu_rd_tick = 1'b1;
    step();
    clear_inputs();
    n_checks++; if (bus.cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL t3_rd_hold: got %0h expected 5a", bus.cpu_rdata); end
    n_checks++; if (bus.cpu_busy !== 1'b1) begin n_fail++; $display("FAIL t3_rd_busy: got %0b expected 1", bus.cpu_busy); end
    step();
    bus.vdp_dma_rd_tick = 1'b1;
    bus.vdp_dma_addr    = 13'h0123;
    step();
    clear_inputs();
    n_checks++; if (bus.cpu_rdata !== 8'h6B) begin n_fail++; $display("FAIL t3_refill_wrap: got %0h expected 6b", bus.cpu_rdata); end
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t3_cap_no_stall: got %0b expected 0", bus.cpu_busy); end
    step();
    n_checks++; if (bus.vram_dout !== 8'hA5) begin n_fail++; $display("FAIL t3_vid_during_cap: got %0h expected a5", bus.vram_dout); end
  endtask

  task automatic test_write_no_read();
    logic [7:0] d;
    cpu_write(8'h3C);
    n_checks++; if (bus.cpu_rdata !== 8'h3C) begin n_fail++; $display("FAIL t4_rdata: got %0h expected 3c", bus.cpu_rdata); end
    n_checks++; if (bus.vram_dout !== 8'hA5) begin n_fail++; $display("FAIL t4_vid_hold: got %0h expected a5", bus.vram_dout); end
    cpu_write(8'h3D);
    video_read(13'h0001, d);
    n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL t4_at_ptr: got %0h expected 3c", d); end
    video_read(13'h0002, d);
    n_checks++; if (d !== 8'h3D) begin n_fail++; $display("FAIL t4_at_ptr_inc: got %0h expected 3d", d); end
  endtask

  task automatic test_overrun();
    set_addr(13'h0400, 1'b0);
    bus.cpu_wr_tick = 1'b1;
    bus.cpu_wdata   = 8'h11;
    step();
    bus.cpu_wdata = 8'h22;
    step();
    clear_inputs();
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t5_drop_busy: got %0b expected 0", bus.cpu_busy); end
    n_checks++; if (bus.cpu_rdata !== 8'h11) begin n_fail++; $display("FAIL t5_drop_rdata: got %0h expected 11", bus.cpu_rdata); end
    n_checks++; if (bus.cpu_overrun !== OVR_EN) begin n_fail++; $display("FAIL t5_ovr_set: got %0b expected %0b", bus.cpu_overrun, OVR_EN); end
    cpu_write(8'h33);
    n_checks++; if (bus.cpu_overrun !== OVR_EN) begin n_fail++; $display("FAIL t5_ovr_sticky: got %0b expected %0b", bus.cpu_overrun, OVR_EN); end
    bus.vdp_dma_rd_tick = 1'b1;
    bus.vdp_dma_addr    = 13'h0400;
    step();
    bus.vdp_dma_addr = 13'h0401;
    step();
    clear_inputs();
    n_checks++; if (bus.vram_dout !== 8'h11) begin n_fail++; $display("FAIL t5_mem400: got %0h expected 11", bus.vram_dout); end
    step();
    n_checks++; if (bus.vram_dout !== 8'h33) begin n_fail++; $display("FAIL t5_mem401: got %0h expected 33", bus.vram_dout); end
    set_addr(13'h0500, 1'b0);
    n_checks++; if (bus.cpu_overrun !== 1'b0) begin n_fail++; $display("FAIL t5_ovr_clear: got %0b expected 0", bus.cpu_overrun); end
    bus.cpu_wr_tick = 1'b1;
    bus.cpu_rd_tick = 1'b1;
    bus.cpu_wdata   = 8'h44;
    step();
    clear_inputs();
    n_checks++; if (bus.cpu_busy !== 1'b1) begin n_fail++; $display("FAIL t5_prio_busy: got %0b expected 1", bus.cpu_busy); end
    step();
    n_checks++; if (bus.cpu_rdata !== 8'h44) begin n_fail++; $display("FAIL t5_prio_wr: got %0h expected 44", bus.cpu_rdata); end
    n_checks++; if (bus.cpu_overrun !== OVR_EN) begin n_fail++; $display("FAIL t5_prio_ovr: got %0b expected %0b", bus.cpu_overrun, OVR_EN); end
    step();
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t5_rd_dropped: got %0b expected 0", bus.cpu_busy); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    set_addr(13'h0600, 1'b0);
    cpu_write(8'h55);
    set_addr(13'h0600, 1'b0);
    bus.cpu_wr_tick     = 1'b1;
    bus.cpu_wdata       = 8'h99;
    bus.vdp_dma_rd_tick = 1'b1;
    bus.vdp_dma_addr    = 13'h0123;
    step();
    bus.cpu_wr_tick = 1'b0;
    step();
    step();
    n_checks++; if (bus.cpu_busy !== 1'b1) begin n_fail++; $display("FAIL t6_stalled: got %0b expected 1", bus.cpu_busy); end
    reset_n = 1'b0;
    step();
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy_cleared: got %0b expected 0", bus.cpu_busy); end
    n_checks++; if (bus.vram_dout !== 8'h00) begin n_fail++; $display("FAIL t6_vram_dout: got %0h expected 00", bus.vram_dout); end
    n_checks++; if (bus.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL t6_cpu_rdata: got %0h expected 00", bus.cpu_rdata); end
    reset_n = 1'b1;
    clear_inputs();
    step();
    step();
    n_checks++; if (bus.cpu_busy !== 1'b0) begin n_fail++; $display("FAIL t6_no_resume: got %0b expected 0", bus.cpu_busy); end
    video_read(13'h0600, d);
    n_checks++; if (d !== 8'h55) begin n_fail++; $display("FAIL t6_byte_kept: got %0h expected 55", d); end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_write_video();
    test_video_stall();
    test_read_wrap();
    test_write_no_read();
    test_overrun();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
